kernel_action_ctrl_master: RTL

//  Host-side initiator that drives a kernel action's control interface: AXI4-Lite master for register

---
 rtl/kernel_ctrl_pkg.sv | 23 ++
 rtl/kernel_ctrl_axil_master.sv | 105 ++++++++++
 rtl/kernel_action_ctrl_master.sv | 132 +++++++++++++
 3 files changed

// File: rtl/kernel_ctrl_pkg.sv
// Shared types for the kernel action control master: register-side and action-side FSM
// state encodings plus the AXI response codes the host cares about.
package kernel_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_REQ,
        S_W_RESP,
        S_R_REQ,
        S_R_DATA,
        S_RSP
    } reg_state_t;

    typedef enum logic [1:0] {
        A_IDLE,
        A_GO,
        A_WAIT
    } act_state_t;

    localparam logic [1:0] AXI_OKAY   = 2'b00;
    localparam logic [1:0] AXI_SLVERR = 2'b10;

endpackage

// File: rtl/kernel_ctrl_axil_master.sv
// Register command engine: turns one host read/write command at a time into AXI4-Lite
// transactions and returns the captured data/response on the rsp channel.
module kernel_ctrl_axil_master
    import kernel_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output reg_state_t  state
);

    reg_state_t  state_q, state_d;
    logic [31:0] addr_q, wdata_q;
    logic        aw_done, w_done;
    logic        cmd_accept, aw_fin, w_fin;

    // Every valid/ready pair here transfers on a rising edge where both are high; the
    // source keeps valid and payload stable until that edge and never waits on ready.
    assign cmd_ready     = (state_q == S_IDLE) && !reset;
    assign cmd_accept    = cmd_valid && cmd_ready;
    assign m_axi_awvalid = (state_q == S_W_REQ) && !aw_done;
    assign m_axi_wvalid  = (state_q == S_W_REQ) && !w_done;
    assign m_axi_bready  = (state_q == S_W_RESP);
    assign m_axi_arvalid = (state_q == S_R_REQ);
    assign m_axi_rready  = (state_q == S_R_DATA);
    assign rsp_valid     = (state_q == S_RSP);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign state         = state_q;

    // AW and W complete independently; the write phase ends once both have gone through.
    assign aw_fin = aw_done || (m_axi_awvalid && m_axi_awready);
    assign w_fin  = w_done  || (m_axi_wvalid && m_axi_wready);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (cmd_accept) state_d = cmd_write ? S_W_REQ : S_R_REQ;
            S_W_REQ:  if (aw_fin && w_fin) state_d = S_W_RESP;
            S_W_RESP: if (m_axi_bvalid) state_d = S_RSP;
            S_R_REQ:  if (m_axi_arready) state_d = S_R_DATA;
            S_R_DATA: if (m_axi_rvalid) state_d = S_RSP;
            S_RSP:    if (rsp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= AXI_OKAY;
        end else begin
            state_q <= state_d;
            if (cmd_accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
            if (m_axi_wvalid && m_axi_wready) w_done <= 1'b1;
            if (m_axi_bready && m_axi_bvalid) begin
                rsp_rdata <= '0;
                rsp_resp  <= m_axi_bresp;
            end
            if (m_axi_rready && m_axi_rvalid) begin
                rsp_rdata <= m_axi_rdata;
                rsp_resp  <= m_axi_rresp;
            end
        end
    end

endmodule

// File: rtl/kernel_action_ctrl_master.sv
// Host-side control master for a kernel action: AXI4-Lite register access via the
// sub-module plus the go/done run handshake with a cycle counter and optional watchdog.
module kernel_action_ctrl_master
    import kernel_ctrl_pkg::*;
#(
    parameter int unsigned RUN_CNT_WIDTH   = 32,
    parameter int unsigned WATCHDOG_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [31:0]              cmd_addr,
    input  logic [31:0]              cmd_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_rdata,
    output logic [1:0]               rsp_resp,
    input  logic                     run_start,
    output logic                     run_busy,
    output logic                     run_done,
    input  logic                     run_done_ready,
    output logic [RUN_CNT_WIDTH-1:0] run_cycles,
    output logic                     run_timeout,
    output logic                     action_go_valid,
    input  logic                     action_go_holdoff,
    input  logic                     action_done_valid,
    output logic                     action_done_stop,
    output logic [31:0]              m_axi_awaddr,
    output logic                     m_axi_awvalid,
    input  logic                     m_axi_awready,
    output logic [31:0]              m_axi_wdata,
    output logic [3:0]               m_axi_wstrb,
    output logic                     m_axi_wvalid,
    input  logic                     m_axi_wready,
    input  logic [1:0]               m_axi_bresp,
    input  logic                     m_axi_bvalid,
    output logic                     m_axi_bready,
    output logic [31:0]              m_axi_araddr,
    output logic                     m_axi_arvalid,
    input  logic                     m_axi_arready,
    input  logic [31:0]              m_axi_rdata,
    input  logic [1:0]               m_axi_rresp,
    input  logic                     m_axi_rvalid,
    output logic                     m_axi_rready,
    output reg_state_t               reg_state,
    output act_state_t               act_state
);

    localparam logic                     WD_EN    = (WATCHDOG_CYCLES != 0);
    localparam logic [RUN_CNT_WIDTH-1:0] WD_LIMIT = RUN_CNT_WIDTH'(WATCHDOG_CYCLES);

    act_state_t               act_q, act_d;
    logic [RUN_CNT_WIDTH-1:0] cnt_q, cnt_inc;
    logic                     go_fire, done_fire;

    kernel_ctrl_axil_master u_axil (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .state         (reg_state)
    );

    // The kernel sees done_stop low only while we wait for done and the consumer can take it.
    assign action_go_valid  = (act_q == A_GO);
    assign action_done_stop = !((act_q == A_WAIT) && run_done_ready);
    assign run_busy         = (act_q != A_IDLE);
    assign go_fire          = action_go_valid && !action_go_holdoff;
    assign done_fire        = (act_q == A_WAIT) && action_done_valid && !action_done_stop;
    assign cnt_inc          = (&cnt_q) ? cnt_q : cnt_q + RUN_CNT_WIDTH'(1);
    assign act_state        = act_q;

    always_comb begin
        act_d = act_q;
        case (act_q)
            A_IDLE:  if (run_start) act_d = A_GO;
            A_GO:    if (go_fire) act_d = A_WAIT;
            A_WAIT:  if (done_fire) act_d = A_IDLE;
            default: act_d = A_IDLE;
        endcase
    end

    // run_cycles counts A_WAIT cycles, so it includes the cycle of the done transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_q       <= A_IDLE;
            cnt_q       <= '0;
            run_cycles  <= '0;
            run_timeout <= 1'b0;
            run_done    <= 1'b0;
        end else begin
            act_q    <= act_d;
            run_done <= done_fire;
            if ((act_q == A_IDLE) && run_start) begin
                cnt_q       <= '0;
                run_timeout <= 1'b0;
            end
            if (act_q == A_WAIT) begin
                cnt_q <= cnt_inc;
                if (WD_EN && (cnt_inc == WD_LIMIT)) run_timeout <= 1'b1;
            end
            if (done_fire) run_cycles <= cnt_inc;
        end
    end

endmodule
